// File: rtl/ireq_arbiter.sv
// ireq_arbiter: round-robin packet arbiter sharing the SRIO ireq AXI4-Stream channel among NUM_REQ requesters; ports: log_clk/log_rst_n, link_initialized, req_* slaves, ireq_* master, grant_o/busy_o/pkt_cnt_o/err_len_o status
module ireq_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int MAX_BEATS = 33
) (
  input  logic                    log_clk,
  input  logic                    log_rst_n,
  input  logic                    link_initialized,
  input  logic [NUM_REQ-1:0]      req_tvalid,
  output logic [NUM_REQ-1:0]      req_tready,
  input  logic [NUM_REQ-1:0]      req_tlast,
  input  logic [64*NUM_REQ-1:0]   req_tdata,
  input  logic [8*NUM_REQ-1:0]    req_tkeep,
  input  logic [32*NUM_REQ-1:0]   req_tuser,
  output logic                    ireq_tvalid_o,
  input  logic                    ireq_tready_in,
  output logic                    ireq_tlast_o,
  output logic [63:0]             ireq_tdata_o,
  output logic [7:0]              ireq_tkeep_o,
  output logic [31:0]             ireq_tuser_o,
  output logic [NUM_REQ-1:0]      grant_o,
  output logic                    busy_o,
  output logic [16*NUM_REQ-1:0]   pkt_cnt_o,
  output logic                    err_len_o
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic {IDLE, LOCK} state_t;
  state_t state, state_n;
  logic [1:0] rst_sync;
  logic rst_n_s;
  logic [IW-1:0] g, rr_ptr, sel;
  logic [5:0] beat_cnt;
  logic found, lock, acc, over, done;
  int k;
  always_ff @(posedge log_clk or negedge log_rst_n)
    if (!log_rst_n) rst_sync <= '0;
    else rst_sync <= {rst_sync[0], 1'b1};
  assign rst_n_s = rst_sync[1];
  always_comb begin
    found = 1'b0;
    sel = rr_ptr;
    k = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(rr_ptr) + i) % NUM_REQ;
      if (!found && req_tvalid[IW'(k)]) begin
        found = 1'b1;
        sel = IW'(k);
      end
    end
  end
  always_comb begin
    lock = state == LOCK;
    over = beat_cnt == 6'(MAX_BEATS) && !req_tlast[g];
    ireq_tvalid_o = lock & req_tvalid[g];
    ireq_tlast_o = lock & (req_tlast[g] | over);
    ireq_tdata_o = lock ? req_tdata[int'(g)*64 +: 64] : '0;
    ireq_tkeep_o = lock ? req_tkeep[int'(g)*8 +: 8] : '0;
    ireq_tuser_o = lock ? req_tuser[int'(g)*32 +: 32] : '0;
    req_tready = grant_o & {NUM_REQ{ireq_tready_in}};
    acc = ireq_tvalid_o & ireq_tready_in;
    done = acc & ireq_tlast_o;
    state_n = lock ? (done ? IDLE : LOCK) : ((link_initialized && found) ? LOCK : IDLE);
  end
  always_ff @(posedge log_clk or negedge rst_n_s)
    if (!rst_n_s) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge log_clk or negedge rst_n_s)
    if (!rst_n_s) begin
      g <= '0;
      rr_ptr <= '0;
      beat_cnt <= '0;
      grant_o <= '0;
      busy_o <= 1'b0;
      err_len_o <= 1'b0;
      pkt_cnt_o <= '0;
    end else begin
      err_len_o <= acc & over;
      if (!lock && state_n == LOCK) begin
        g <= sel;
        grant_o <= NUM_REQ'(1) << sel;
        busy_o <= 1'b1;
        beat_cnt <= '0;
      end else if (acc) begin
        beat_cnt <= beat_cnt + 6'd1;
        if (done) begin
          grant_o <= '0;
          busy_o <= 1'b0;
          rr_ptr <= (int'(g) == NUM_REQ - 1) ? '0 : g + 1'b1;
          pkt_cnt_o[int'(g)*16 +: 16] <= pkt_cnt_o[int'(g)*16 +: 16] + 16'd1;
        end
      end
    end
endmodule

// File: tb/tb_ireq_arbiter.sv
// tb_ireq_arbiter: directed self-checking bench for ireq_arbiter
module tb_ireq_arbiter;
  localparam int N = 2;
  logic log_clk = 1'b0, log_rst_n = 1'b1, link_initialized = 1'b0, ireq_tready_in = 1'b0;
  logic [N-1:0] req_tvalid = '0, req_tlast = '0, req_tready;
  logic [64*N-1:0] req_tdata = '0;
  logic [8*N-1:0] req_tkeep = '0;
  logic [32*N-1:0] req_tuser = '0;
  logic ireq_tvalid_o, ireq_tlast_o, busy_o, err_len_o;
  logic [63:0] ireq_tdata_o;
  logic [7:0] ireq_tkeep_o;
  logic [31:0] ireq_tuser_o;
  logic [N-1:0] grant_o;
  logic [16*N-1:0] pkt_cnt_o;
  int n_vec = 0, n_err = 0;
  int src_len[N], src_pkts[N], src_beat[N];
  bit use_src = 1'b0;
  ireq_arbiter #(.NUM_REQ(N), .MAX_BEATS(33)) dut (
    .log_clk(log_clk), .log_rst_n(log_rst_n), .link_initialized(link_initialized),
    .req_tvalid(req_tvalid), .req_tready(req_tready), .req_tlast(req_tlast),
    .req_tdata(req_tdata), .req_tkeep(req_tkeep), .req_tuser(req_tuser),
    .ireq_tvalid_o(ireq_tvalid_o), .ireq_tready_in(ireq_tready_in), .ireq_tlast_o(ireq_tlast_o),
    .ireq_tdata_o(ireq_tdata_o), .ireq_tkeep_o(ireq_tkeep_o), .ireq_tuser_o(ireq_tuser_o),
    .grant_o(grant_o), .busy_o(busy_o), .pkt_cnt_o(pkt_cnt_o), .err_len_o(err_len_o)
  );
  always #5 log_clk = ~log_clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] src_word(input int i);
    return {16'hA5A5, 16'(i), 16'(src_pkts[i]), 16'(src_beat[i])};
  endfunction
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_tvalid[i] = src_pkts[i] > 0;
      req_tlast[i] = src_beat[i] == src_len[i] - 1;
      req_tdata[64*i +: 64] = src_word(i);
      req_tkeep[8*i +: 8] = 8'hFF;
      req_tuser[32*i +: 32] = {16'(i + 16), 16'h00F1};
    end
  endtask
  task automatic step();
    logic [N-1:0] hs;
    @(negedge log_clk);
    hs = req_tvalid & req_tready;
    @(posedge log_clk);
    #1;
    if (use_src) begin
      for (int i = 0; i < N; i++)
        if (hs[i]) begin
          src_beat[i]++;
          if (src_beat[i] == src_len[i]) begin
            src_beat[i] = 0;
            src_pkts[i]--;
          end
        end
      drive();
    end
    #1;
  endtask
  task automatic wait_idle(input string tag, input int max);
    int n;
    n = 0;
    while (busy_o && n < max) begin
      step();
      n++;
    end
    chk(tag, busy_o, 0);
  endtask
  task automatic load(input int l0, input int p0, input int l1, input int p1);
    src_len[0] = l0; src_pkts[0] = p0; src_beat[0] = 0;
    src_len[1] = l1; src_pkts[1] = p1; src_beat[1] = 0;
    drive();
    #1;
  endtask
  initial begin
    int exp_g[16] = '{1, 1, 1, 0, 2, 2, 2, 0, 1, 1, 1, 0, 2, 2, 2, 0};
    bit rdy[6] = '{1, 0, 0, 1, 1, 1};
    int exp_beat[6] = '{0, 1, 1, 1, 2, 3};
    int acc_n, err_n, err_beat, first_tlast, last_acc;
    logic [N-1:0] seen;
    #2 log_rst_n = 1'b0;
    repeat (3) @(posedge log_clk);
    #1;
    chk("rst_grant", grant_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_len_o, 0);
    chk("rst_cnt", pkt_cnt_o, 0);
    chk("rst_valid", ireq_tvalid_o, 0);
    chk("rst_ready", req_tready, 0);
    log_rst_n = 1'b1;
    use_src = 1'b1;
    load(1, 0, 1, 0);
    repeat (3) step();
    // contention: 3-beat packets from both requesters
    link_initialized = 1'b1;
    ireq_tready_in = 1'b1;
    load(3, 2, 3, 2);
    for (int c = 0; c < 16; c++) begin
      step();
      chk($sformatf("cont_grant%0d", c), grant_o, exp_g[c]);
      chk($sformatf("cont_valid%0d", c), ireq_tvalid_o, exp_g[c] != 0);
      if (exp_g[c] != 0) chk($sformatf("cont_data%0d", c), ireq_tdata_o, src_word(exp_g[c] - 1));
    end
    chk("cont_cnt0", pkt_cnt_o[15:0], 2);
    chk("cont_cnt1", pkt_cnt_o[31:16], 2);
    // single doorbell on requester 0
    use_src = 1'b0;
    req_tdata[63:0] = 64'h00A0_2000_0000_0101;
    req_tuser[31:0] = 32'h00F0_00F1;
    req_tkeep[7:0] = 8'hFF;
    req_tlast[0] = 1'b1;
    req_tvalid[0] = 1'b1;
    #1;
    chk("db_pre_grant", grant_o, 0);
    chk("db_pre_valid", ireq_tvalid_o, 0);
    step();
    chk("db_grant", grant_o, 1);
    chk("db_busy", busy_o, 1);
    chk("db_valid", ireq_tvalid_o, 1);
    chk("db_data", ireq_tdata_o, 64'h00A0_2000_0000_0101);
    chk("db_user", ireq_tuser_o, 32'h00F0_00F1);
    chk("db_keep", ireq_tkeep_o, 8'hFF);
    chk("db_last", ireq_tlast_o, 1);
    chk("db_ready", req_tready, 2'b01);
    step();
    req_tvalid[0] = 1'b0;
    #1;
    chk("db_busy_end", busy_o, 0);
    chk("db_grant_end", grant_o, 0);
    chk("db_cnt0", pkt_cnt_o[15:0], 3);
    // backpressure on a 4-beat NWRITE from requester 1
    use_src = 1'b1;
    load(1, 0, 4, 1);
    step();
    chk("bp_grant", grant_o, 2'b10);
    acc_n = 0;
    for (int c = 0; c < 6; c++) begin
      ireq_tready_in = rdy[c];
      #1;
      chk($sformatf("bp_ready%0d", c), req_tready, {rdy[c], 1'b0});
      chk($sformatf("bp_beat%0d", c), ireq_tdata_o[15:0], exp_beat[c]);
      if (ireq_tvalid_o && ireq_tready_in) acc_n++;
      step();
    end
    chk("bp_beats", acc_n, 4);
    chk("bp_idle", busy_o, 0);
    chk("bp_cnt1", pkt_cnt_o[31:16], 3);
    // link gating
    ireq_tready_in = 1'b1;
    link_initialized = 1'b0;
    load(2, 1, 2, 1);
    seen = '0;
    repeat (10) begin
      step();
      seen |= grant_o;
    end
    chk("link_down_grant", seen, 0);
    link_initialized = 1'b1;
    step();
    chk("link_up_grant", grant_o, 2'b01);
    link_initialized = 1'b0;
    wait_idle("link_drop_finish", 10);
    chk("link_drop_cnt0", pkt_cnt_o[15:0], 4);
    seen = '0;
    repeat (5) begin
      step();
      seen |= grant_o;
    end
    chk("link_drop_nogrant", seen, 0);
    link_initialized = 1'b1;
    step();
    chk("link_up2_grant", grant_o, 2'b10);
    wait_idle("link_up2_finish", 10);
    chk("link_cnt1", pkt_cnt_o[31:16], 4);
    // overlong 40-beat packet from requester 1
    load(1, 0, 40, 1);
    step();
    chk("ovl_grant", grant_o, 2'b10);
    err_n = 0; err_beat = -1; first_tlast = -1; last_acc = -1;
    for (int c = 0; c < 60 && (src_pkts[1] > 0 || busy_o); c++) begin
      if (err_len_o) begin
        err_n++;
        err_beat = last_acc;
      end
      if (ireq_tvalid_o && ireq_tready_in) begin
        last_acc = src_beat[1];
        if (ireq_tlast_o && first_tlast < 0) first_tlast = src_beat[1];
      end
      step();
      if (err_len_o && last_acc == 33) chk("ovl_gap", grant_o, 0);
    end
    chk("ovl_done", src_pkts[1], 0);
    chk("ovl_err_count", err_n, 1);
    chk("ovl_err_beat", err_beat, 33);
    chk("ovl_forced_tlast", first_tlast, 33);
    chk("ovl_cnt1", pkt_cnt_o[31:16], 6);
    // reset in the middle of a packet
    load(1, 1, 1, 0);
    step();
    wait_idle("rst_pre_pkt", 5);
    load(1, 0, 4, 1);
    step();
    chk("rst_pre_grant", grant_o, 2'b10);
    step();
    log_rst_n = 1'b0;
    #1;
    chk("rstm_grant", grant_o, 0);
    chk("rstm_busy", busy_o, 0);
    chk("rstm_valid", ireq_tvalid_o, 0);
    chk("rstm_last", ireq_tlast_o, 0);
    chk("rstm_data", ireq_tdata_o, 0);
    chk("rstm_ready", req_tready, 0);
    chk("rstm_cnt", pkt_cnt_o, 0);
    load(1, 0, 1, 0);
    log_rst_n = 1'b1;
    repeat (3) step();
    load(1, 1, 1, 1);
    chk("rstm_pre", grant_o, 0);
    step();
    chk("rstm_first_grant", grant_o, 2'b01);
    wait_idle("rstm_finish", 5);
    chk("rstm_cnt0", pkt_cnt_o[15:0], 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
